// File: rtl/fifo_rd_stream.sv
// Read-side adapter: pops an async FIFO (1-cycle read latency) into a 2-entry
// skid buffer and presents the words as a valid/ready stream.
//
// state | meaning
// EMPTY | no buffered word, m_valid low
// ONE   | head holds the next word
// TWO   | head and tail both hold words, head delivered first
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_rd_en,
  input  logic                  flush,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic                  overrun
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  occ_t                  state_q, state_d;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic                  overrun_q, overrun_d;
  logic [CNT_WIDTH-1:0]  count_q;
  logic                  pop;
  logic                  arrive;
  logic [2:0]            demand;

  assign m_valid    = (state_q != EMPTY);
  assign m_data     = head_q;
  assign word_count = count_q;
  assign overrun    = overrun_q;
  assign pop        = m_valid && m_ready;
  // A word landing during flush belongs to the discarded stream.
  assign arrive     = inflight_q && !flush;

  // Slots committed after this edge; a new pop is allowed only if one stays free.
  assign demand     = {1'b0, state_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign fifo_rd_en = !fifo_empty && !flush && !rrst && (demand < 3'd2);

  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    tail_d    = tail_q;
    overrun_d = overrun_q;
    case (state_q)
      EMPTY: begin
        if (arrive) begin
          state_d = ONE;
          head_d  = fifo_rdata;
        end
      end
      ONE: begin
        if (arrive && pop) begin
          head_d = fifo_rdata;
        end else if (arrive) begin
          state_d = TWO;
          tail_d  = fifo_rdata;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop && arrive) begin
          head_d = tail_q;
          tail_d = fifo_rdata;
        end else if (pop) begin
          state_d = ONE;
          head_d  = tail_q;
        end else if (arrive) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q    <= EMPTY;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      overrun_q  <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= fifo_rd_en;
      head_q     <= head_d;
      tail_q     <= tail_d;
      overrun_q  <= overrun_d;
      count_q    <= count_q + {{(CNT_WIDTH-1){1'b0}}, pop};
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural 1-cycle-latency FIFO;
// word_count is 4 bits here so the wrap is reachable.
module tb_fifo_rd_stream;

  logic       rclk = 1'b0;
  logic       rrst;
  logic       fifo_empty;
  logic [7:0] fifo_rdata;
  logic       fifo_rd_en;
  logic       flush;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
  logic [3:0] word_count;
  logic       overrun;

  logic [7:0] fq[$];
  logic [7:0] rx[$];
  logic       force_empty;
  int         n_rd;
  int         bad_rd;
  int         errs;
  int         checks;

  fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut (
    .rclk       (rclk),
    .rrst       (rrst),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_rd_en (fifo_rd_en),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .word_count (word_count),
    .overrun    (overrun)
  );

  always #5 rclk = ~rclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: settle inputs, observe the pre-edge state, clock, then
  // present the popped word (valid one cycle after the rd_en edge).
  task automatic cyc();
    logic rd_s;
    fifo_empty = force_empty || (fq.size() == 0);
    #1;
    rd_s = fifo_rd_en;
    if (rd_s && fifo_empty) bad_rd++;
    if (rd_s) n_rd++;
    if (m_valid && m_ready) rx.push_back(m_data);
    @(posedge rclk);
    @(negedge rclk);
    if (rd_s && fq.size() > 0) fifo_rdata = fq.pop_front();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset();
    rrst = 1'b1;
    fq.delete();
    run(2);
    rrst = 1'b0;
    rx.delete();
    n_rd = 0;
  endtask

  initial begin
    errs = 0; checks = 0; n_rd = 0; bad_rd = 0;
    rrst = 1'b1; flush = 1'b0; m_ready = 1'b0; force_empty = 1'b0;
    fifo_rdata = 8'h00; fifo_empty = 1'b1;
    @(negedge rclk);

    // Reset holds everything at zero and blocks pops even with data waiting.
    fq.push_back(8'hEE);
    run(2);
    fifo_empty = 1'b0;
    #1;
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_count", word_count, 0);
    check("rst_overrun", overrun, 0);

    // Streaming 25 words at full rate.
    do_reset();
    for (int i = 1; i <= 25; i++) fq.push_back(8'(i));
    m_ready = 1'b1;
    run(2);
    check("stream_latency_rx", rx.size(), 0);
    check("stream_latency_valid", m_valid, 1);
    check("stream_first_data", m_data, 8'h01);
    run(24);
    check("stream_rx_24", rx.size(), 24);
    run(1);
    check("stream_rx_25", rx.size(), 25);
    for (int i = 0; i < 25 && i < rx.size(); i++)
      if (rx[i] !== 8'(i + 1)) check($sformatf("stream_word%0d", i), rx[i], 8'(i + 1));
    check("stream_count_mod16", word_count, 4'd9);
    check("stream_overrun", overrun, 0);
    check("stream_drained", m_valid, 0);

    // Backpressure: only two pops, head held stable.
    do_reset();
    m_ready = 1'b0;
    fq.push_back(8'h31); fq.push_back(8'h32); fq.push_back(8'h33);
    run(4);
    check("bp_rd_pulses", n_rd, 2);
    check("bp_valid", m_valid, 1);
    check("bp_head", m_data, 8'h31);
    check("bp_fifo_left", fq.size(), 1);
    run(3);
    check("bp_head_stable", m_data, 8'h31);
    check("bp_rd_still", n_rd, 2);
    m_ready = 1'b1;
    run(3);
    check("bp_rx_n", rx.size(), 3);
    if (rx.size() == 3) begin
      check("bp_rx0", rx[0], 8'h31);
      check("bp_rx1", rx[1], 8'h32);
      check("bp_rx2", rx[2], 8'h33);
    end
    check("bp_count", word_count, 3);

    // Empty flag toggling every cycle.
    do_reset();
    for (int i = 0; i < 8; i++) fq.push_back(8'h40 + 8'(i));
    for (int i = 0; i < 30; i++) begin
      force_empty = i[0];
      cyc();
    end
    force_empty = 1'b0;
    check("tog_rx_n", rx.size(), 8);
    for (int i = 0; i < 8 && i < rx.size(); i++)
      if (rx[i] !== 8'h40 + 8'(i)) check($sformatf("tog_word%0d", i), rx[i], 8'h40 + 8'(i));

    // Flush with a word in flight, pop coincident with flush.
    do_reset();
    m_ready = 1'b0;
    fq.push_back(8'hA0); fq.push_back(8'hA1); fq.push_back(8'hA2); fq.push_back(8'hA3);
    run(4);
    check("fl_two_head", m_data, 8'hA0);
    check("fl_two_rd", n_rd, 2);
    m_ready = 1'b1;
    run(1);
    check("fl_pre_head", m_data, 8'hA1);
    flush = 1'b1;
    run(1);
    flush = 1'b0;
    check("fl_valid_low", m_valid, 0);
    check("fl_count", word_count, 2);
    run(4);
    check("fl_rx_n", rx.size(), 3);
    if (rx.size() == 3) begin
      check("fl_rx0", rx[0], 8'hA0);
      check("fl_rx1", rx[1], 8'hA1);
      check("fl_rx2_after", rx[2], 8'hA3);
    end
    check("fl_count_end", word_count, 3);

    // Reset with 0x55 in flight.
    do_reset();
    m_ready = 1'b1;
    fq.push_back(8'h53); fq.push_back(8'h54); fq.push_back(8'h55); fq.push_back(8'h56);
    run(3);
    rrst = 1'b1;
    run(1);
    fifo_empty = force_empty || (fq.size() == 0);
    #1;
    check("mrst_valid", m_valid, 0);
    check("mrst_data", m_data, 0);
    check("mrst_count", word_count, 0);
    check("mrst_overrun", overrun, 0);
    check("mrst_rd_en", fifo_rd_en, 0);
    rrst = 1'b0;
    run(4);
    check("mrst_rx_n", rx.size(), 3);
    if (rx.size() == 3) check("mrst_next", rx[2], 8'h56);

    // 4-bit counter wrap.
    do_reset();
    for (int i = 0; i < 17; i++) fq.push_back(8'h70 + 8'(i));
    m_ready = 1'b1;
    run(18);
    check("wrap_16", word_count, 0);
    run(1);
    check("wrap_17", word_count, 1);
    check("final_overrun", overrun, 0);
    check("no_underflow_pops", bad_rd, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
